// File: rtl/game_round_ctrl.sv
// ---------------------------------------------------------------------------
// game_round_ctrl
//
// Round sequencer for a mental-arithmetic game. A round shows NUM_VALUES
// random operands (one per display phase), blanks the display, waits for
// the player's answer, compares it against the operand total modulo 100,
// shows the correct total and updates a saturating score.
//
// Optional feature macro: ANSWER_TIMEOUT_EN
//   When defined, WAIT_ANS gives up after ANS_PHASES display phases and the
//   round is scored wrong. Undefined (default): WAIT_ANS waits indefinitely.
//
// Parameters
//   PHASE_TICKS  clock cycles per display phase (>= 2)
//   NUM_VALUES   operands per round (1..7)
//   ANS_PHASES   answer-window length in phases (timeout build only)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       round request, honoured only in IDLE
//   rand_in     operand from the external LFSR
//   rand_req    one-cycle request to advance the LFSR
//   ans_in      player answer (binary)
//   ans_valid   answer strobe
//   ans_ready   high only in WAIT_ANS
//   disp_out    value for the BCD display path (ans_in passes live in WAIT_ANS)
//   phase       encoded FSM state
//   score       saturating count of correct rounds (cleared by reset only)
//   correct     result of the last round, held until the next round starts
//   round_done  one-cycle pulse as RESULT exits
//   busy        high in every state except IDLE
// ---------------------------------------------------------------------------
module game_round_ctrl #(
    parameter int unsigned PHASE_TICKS = 10,
    parameter int unsigned NUM_VALUES  = 5,
    parameter int unsigned ANS_PHASES  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [4:0] rand_in,
    output logic       rand_req,
    input  logic [7:0] ans_in,
    input  logic       ans_valid,
    output logic       ans_ready,
    output logic [7:0] disp_out,
    output logic [2:0] phase,
    output logic [2:0] score,
    output logic       correct,
    output logic       round_done,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SHOW     = 3'd1,
        S_BLANK    = 3'd2,
        S_WAIT_ANS = 3'd3,
        S_CHECK    = 3'd4,
        S_RESULT   = 3'd5
    } state_t;

    localparam int unsigned   TW         = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(PHASE_TICKS - 1);
    localparam logic [TW-1:0] TICK_LATCH = TW'(1);
    localparam logic [2:0]    SLOT_LAST  = 3'(NUM_VALUES - 1);

    state_t        r_state, w_state_nxt;
    logic [TW-1:0] r_tick, w_tick_nxt, w_tick_inc;
    logic [2:0]    r_slot, w_slot_nxt;
    logic [6:0]    r_sum, w_sum_nxt, w_sum_mod;
    logic [7:0]    w_sum_add;
    logic [7:0]    r_disp, w_disp_nxt;
    logic [7:0]    r_ans, w_ans_nxt;
    logic [2:0]    r_score, w_score_nxt;
    logic          r_correct, w_correct_nxt;
    logic          r_rand_req, w_rand_req_nxt;
    logic          r_round_done, w_round_done_nxt;

`ifdef ANSWER_TIMEOUT_EN
    localparam int unsigned   PW       = (ANS_PHASES > 1) ? $clog2(ANS_PHASES) : 1;
    localparam logic [PW-1:0] APH_LAST = PW'(ANS_PHASES - 1);
    logic [PW-1:0] r_aph, w_aph_nxt;
`endif

    assign w_tick_inc = r_tick + TW'(1);

    // Running total kept modulo 100: r_sum <= 99 and rand_in <= 31, so a
    // single conditional subtract is enough.
    assign w_sum_add = {1'b0, r_sum} + {3'b000, rand_in};
    assign w_sum_mod = (w_sum_add >= 8'd100) ? 7'(w_sum_add - 8'd100) : w_sum_add[6:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_tick       <= '0;
            r_slot       <= '0;
            r_sum        <= '0;
            r_disp       <= '0;
            r_ans        <= '0;
            r_score      <= '0;
            r_correct    <= 1'b0;
            r_rand_req   <= 1'b0;
            r_round_done <= 1'b0;
`ifdef ANSWER_TIMEOUT_EN
            r_aph        <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_tick       <= w_tick_nxt;
            r_slot       <= w_slot_nxt;
            r_sum        <= w_sum_nxt;
            r_disp       <= w_disp_nxt;
            r_ans        <= w_ans_nxt;
            r_score      <= w_score_nxt;
            r_correct    <= w_correct_nxt;
            r_rand_req   <= w_rand_req_nxt;
            r_round_done <= w_round_done_nxt;
`ifdef ANSWER_TIMEOUT_EN
            r_aph        <= w_aph_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_tick_nxt       = r_tick;
        w_slot_nxt       = r_slot;
        w_sum_nxt        = r_sum;
        w_disp_nxt       = r_disp;
        w_ans_nxt        = r_ans;
        w_score_nxt      = r_score;
        w_correct_nxt    = r_correct;
        w_rand_req_nxt   = 1'b0;
        w_round_done_nxt = 1'b0;
`ifdef ANSWER_TIMEOUT_EN
        w_aph_nxt        = r_aph;
`endif

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt    = S_SHOW;
                    w_tick_nxt     = '0;
                    w_slot_nxt     = '0;
                    w_sum_nxt      = '0;
                    w_correct_nxt  = 1'b0;
                    w_rand_req_nxt = 1'b1;
                end
            end

            S_SHOW: begin
                // The LFSR was advanced during tick 0, so its new value is
                // stable by tick 1.
                if (r_tick == TICK_LATCH) begin
                    w_disp_nxt = {3'b000, rand_in};
                    w_sum_nxt  = w_sum_mod;
                end
                if (r_tick == TICK_LAST) begin
                    w_tick_nxt = '0;
                    if (r_slot == SLOT_LAST) begin
                        w_state_nxt = S_BLANK;
                        w_disp_nxt  = '0;
                    end else begin
                        w_slot_nxt     = r_slot + 3'd1;
                        w_rand_req_nxt = 1'b1;
                    end
                end else begin
                    w_tick_nxt = w_tick_inc;
                end
            end

            S_BLANK: begin
                if (r_tick == TICK_LAST) begin
                    w_state_nxt = S_WAIT_ANS;
                    w_tick_nxt  = '0;
`ifdef ANSWER_TIMEOUT_EN
                    w_aph_nxt   = '0;
`endif
                end else begin
                    w_tick_nxt = w_tick_inc;
                end
            end

            S_WAIT_ANS: begin
                if (ans_valid) begin
                    w_ans_nxt   = ans_in;
                    w_disp_nxt  = ans_in;
                    w_state_nxt = S_CHECK;
                    w_tick_nxt  = '0;
                end
`ifdef ANSWER_TIMEOUT_EN
                else if (r_tick == TICK_LAST) begin
                    w_tick_nxt = '0;
                    if (r_aph == APH_LAST) begin
                        // 0xFF can never equal a total <= 99, so CHECK scores
                        // the expired round wrong without a separate flag.
                        w_ans_nxt   = 8'hFF;
                        w_disp_nxt  = '0;
                        w_state_nxt = S_CHECK;
                    end else begin
                        w_aph_nxt = r_aph + PW'(1);
                    end
                end else begin
                    w_tick_nxt = w_tick_inc;
                end
`endif
            end

            S_CHECK: begin
                w_correct_nxt = (r_ans == {1'b0, r_sum});
                if ((r_ans == {1'b0, r_sum}) && (r_score != 3'd7)) begin
                    w_score_nxt = r_score + 3'd1;
                end
                w_disp_nxt  = {1'b0, r_sum};
                w_state_nxt = S_RESULT;
                w_tick_nxt  = '0;
            end

            S_RESULT: begin
                if (r_tick == TICK_LAST) begin
                    w_round_done_nxt = 1'b1;
                    w_state_nxt      = S_IDLE;
                    w_tick_nxt       = '0;
                end else begin
                    w_tick_nxt = w_tick_inc;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_tick_nxt  = '0;
            end
        endcase
    end

    assign rand_req   = r_rand_req;
    assign round_done = r_round_done;
    assign correct    = r_correct;
    assign score      = r_score;
    assign phase      = r_state;
    assign busy       = (r_state != S_IDLE);
    assign ans_ready  = (r_state == S_WAIT_ANS);
    assign disp_out   = (r_state == S_WAIT_ANS) ? ans_in : r_disp;

endmodule

// File: tb/tb_game_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_round_ctrl
//
// Table-driven bench for game_round_ctrl (PHASE_TICKS=4, NUM_VALUES=5,
// ANS_PHASES=2). Each table record is one round: operands fed on rand_req,
// the answer, and the expected total / result. Expected results are queued
// when the answer is given and popped when round_done pulses.
// ---------------------------------------------------------------------------
module tb_game_round_ctrl;

    localparam int unsigned PT = 4;
    localparam int unsigned NV = 5;
    localparam int unsigned AP = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] rand_in;
    logic       rand_req;
    logic [7:0] ans_in;
    logic       ans_valid;
    logic       ans_ready;
    logic [7:0] disp_out;
    logic [2:0] phase;
    logic [2:0] score;
    logic       correct;
    logic       round_done;
    logic       busy;

    always #5 clk = ~clk;

    game_round_ctrl #(
        .PHASE_TICKS (PT),
        .NUM_VALUES  (NV),
        .ANS_PHASES  (AP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rand_in    (rand_in),
        .rand_req   (rand_req),
        .ans_in     (ans_in),
        .ans_valid  (ans_valid),
        .ans_ready  (ans_ready),
        .disp_out   (disp_out),
        .phase      (phase),
        .score      (score),
        .correct    (correct),
        .round_done (round_done),
        .busy       (busy)
    );

    typedef struct {
        logic [0:NV-1][4:0] ops;
        int                 ans;
        int                 exp_sum;
        bit                 exp_ok;
        bit                 noise;
        bit                 start_exit;
        bit                 no_ans;
    } vec_t;

    typedef struct {
        bit ok;
        int score;
        int sum;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[15];
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   m_score = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input int o0, input int o1, input int o2, input int o3,
                                input int o4, input int ans, input int exp_sum,
                                input bit ok, input bit noise, input bit sx, input bit na);
        vec_t v;
        v.ops        = {5'(o0), 5'(o1), 5'(o2), 5'(o3), 5'(o4)};
        v.ans        = ans;
        v.exp_sum    = exp_sum;
        v.exp_ok     = ok;
        v.noise      = noise;
        v.start_exit = sx;
        v.no_ans     = na;
        return v;
    endfunction

    task automatic push_exp(input bit ok, input int sum);
        exp_t e;
        if (ok && m_score < 7) m_score++;
        e.ok    = ok;
        e.score = m_score;
        e.sum   = sum;
        sb_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_disp"}, disp_out, 0);
        chk({tag, "_phase"}, phase, 0);
        chk({tag, "_score"}, score, 0);
        chk({tag, "_correct"}, correct, 0);
        chk({tag, "_rand_req"}, rand_req, 0);
        chk({tag, "_round_done"}, round_done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ans_ready"}, ans_ready, 0);
    endtask

    task automatic run_round(input vec_t v);
        int   c;
        int   ptr;
        int   nreq;
        int   rc;
        bit   done;
        exp_t e;
        ptr  = 0;
        nreq = 0;
        chk("idle_before_start", phase, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("show_entry", phase, 1);
        chk("busy_in_show", busy, 1);
        chk("rand_req_on_start", rand_req, 1);

        c = 0;
        while (phase != 3'd3 && c < 100) begin
            if (rand_req) begin
                nreq++;
                if (ptr < NV) begin
                    rand_in = v.ops[ptr];
                    ptr++;
                end
            end
            if (phase == 3'd1 && (c % PT) == 2 && (c / PT) < NV)
                chk("show_disp", disp_out, v.ops[c / PT]);
            if (c == NV * PT) begin
                chk("blank_phase", phase, 2);
                chk("blank_disp", disp_out, 0);
            end
            if (v.noise) begin
                start     = (c == 5);
                ans_valid = (c == 5) || (c == NV * PT + 1);
                ans_in    = 8'(v.exp_sum);
            end
            step();
            c++;
        end
        start     = 1'b0;
        ans_valid = 1'b0;
        chk("wait_entry_cycle", c, NV * PT + PT);
        chk("rand_req_count", nreq, NV);
        chk("ans_ready_in_wait", ans_ready, 1);

        if (!v.no_ans) begin
            ans_in = 8'(v.ans);
            #1;
            chk("live_disp", disp_out, v.ans);
            ans_valid = 1'b1;
            push_exp(v.exp_ok, v.exp_sum);
            step();
            ans_valid = 1'b0;
            chk("check_phase", phase, 4);
        end else begin
`ifdef ANSWER_TIMEOUT_EN
            ans_in = 8'(v.exp_sum);
            c = 0;
            while (phase == 3'd3 && c < 100) begin
                step();
                c++;
            end
            chk("timeout_cycles", c, PT * AP);
            chk("timeout_check_phase", phase, 4);
            push_exp(1'b0, v.exp_sum);
            // A correct answer strobed after the window closed must not count.
            ans_valid = 1'b1;
`else
            ans_in = 8'(v.exp_sum);
            repeat (5 * PT * AP) step();
            chk("no_timeout_still_waiting", phase, 3);
            return;
`endif
        end

        rc   = 0;
        done = 1'b0;
        c    = 0;
        while (!done && c < 40) begin
            if (phase == 3'd5) begin
                rc++;
                if (rc == 1) chk("result_disp", disp_out, v.exp_sum);
                start = v.start_exit && (rc == PT);
            end
            step();
            c++;
            if (round_done) begin
                done = 1'b1;
                chk("sb_depth", sb_q.size(), 1);
                e = sb_q.pop_front();
                chk("correct", correct, e.ok);
                chk("score", score, e.score);
                chk("idle_after_result", phase, 0);
                chk("busy_after_result", busy, 0);
                chk("result_cycles", rc, PT);
            end
        end
        chk("round_done_seen", done, 1);
        start     = 1'b0;
        ans_valid = 1'b0;
        step();
        chk("round_done_width", round_done, 0);
        chk("stays_idle", phase, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        rand_in   = '0;
        ans_in    = '0;
        ans_valid = 1'b0;

        //             operands             ans  sum ok noise sx  na
        tbl[0] = mk( 3,  7, 12, 30, 31,     83,  83, 1, 0,    0,  0);
        tbl[1] = mk( 3,  7, 12, 30, 31,     82,  83, 0, 1,    0,  0);
        tbl[2] = mk(31, 31, 31, 31, 31,     55,  55, 1, 0,    1,  0);
        tbl[3] = mk( 3,  7, 12, 30, 31,    211,  83, 0, 0,    0,  0);
        tbl[4] = mk(31, 31, 31,  7,  0,      0,   0, 1, 0,    0,  0);
        tbl[5] = mk(31, 31, 31,  6,  0,     99,  99, 1, 0,    0,  0);
        for (int i = 0; i < 8; i++) begin
            int s;
            s = (31 + 31 + 4 * i + 20 + i) % 100;
            tbl[6 + i] = mk(31, 31, 4 * i, 20, i, s, s, 1, 0, 0, 0);
        end
        tbl[14] = mk(3, 7, 12, 30, 31, 0, 83, 0, 0, 0, 1);

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_round(tbl[i]);

        // Reset in the middle of the third operand slot.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (rand_req) rand_in = 5'(k + 3);
            step();
        end
        chk("pre_reset_show", phase, 1);
        chk("pre_reset_score", score, 4);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("mid_show_reset");
        m_score = 0;
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 6; i < 14; i++) run_round(tbl[i]);
        run_round(tbl[14]);

`ifndef ANSWER_TIMEOUT_EN
        #2 rst_n = 1'b0;
        #1;
        chk("mid_wait_reset_phase", phase, 0);
        chk("mid_wait_reset_disp", disp_out, 0);
        chk("mid_wait_reset_ready", ans_ready, 0);
        chk("mid_wait_reset_score", score, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 Parameter PHASE_TICKS, default 10: clock cycles per display phase (must be at least 2).
REQ-002 Parameter NUM_VALUES, default 5: operands per round (1..7).
REQ-003 Parameter ANS_PHASES, default 8: answer-window length in phases; used only with ANSWER_TIMEOUT_EN.
REQ-004 clk  in  1: single system clock; all state changes on its rising edge.
REQ-005 rst_n  in  1: asynchronous reset, active-low.
REQ-006 start  in  1: one-cycle round request, honoured only in IDLE.
REQ-007 rand_in  in  5: operand source from the LFSR.
REQ-008 rand_req  out  1: one-cycle pulse asking the LFSR to advance.
REQ-009 ans_in  in  8: player answer, binary.
REQ-010 ans_valid  in  1: answer strobe.
REQ-011 ans_ready  out  1: high only in WAIT_ANS.
REQ-012 disp_out  out  8: value to the BCD display path.
REQ-013 phase  out  3: encoded FSM state.
REQ-014 score  out  3: saturating correct-round count.
REQ-015 correct  out  1: result of the last round, held until the next round starts.
REQ-016 round_done  out  1: one-cycle pulse when RESULT exits.
REQ-017 busy  out  1: high in every state except IDLE.

Function
REQ-018 States and encodings SHALL be:
- IDLE=0
- SHOW=1
- BLANK=2
- WAIT_ANS=3
- CHECK=4
- RESULT=5
REQ-019 tick_cnt SHALL count 0..PHASE_TICKS-1 in SHOW, BLANK, RESULT and (with the macro) WAIT_ANS; it clears on every state or slot change.
REQ-020 IDLE SHALL go to SHOW on start==1, clearing sum, slot index and correct, and pulsing rand_req in the same cycle.
REQ-021 SHOW SHALL present NUM_VALUES slots of PHASE_TICKS cycles each.
- On tick 1 of each slot: latch rand_in into disp_out and add it to sum.
- On the last tick of a non-final slot: pulse rand_req and advance the slot.
- On the last tick of the final slot: go to BLANK.
REQ-022 sum SHALL be 7 bits, updated as sum+v, minus 100 if that is at least 100, so sum always equals the operand total modulo 100.
REQ-023 BLANK SHALL drive disp_out=0 for PHASE_TICKS cycles, then go to WAIT_ANS.
REQ-024 WAIT_ANS SHALL drive disp_out=ans_in live; on ans_valid&&ans_ready it captures ans_in and goes to CHECK the next cycle.
REQ-025 CHECK SHALL last one cycle.
- Set correct = (captured answer == {1'b0,sum}).
- Increment score if correct, saturating at 7.
- Go to RESULT.
REQ-026 RESULT SHALL drive disp_out={1'b0,sum} for PHASE_TICKS cycles, then pulse round_done and return to IDLE.
REQ-027 start outside IDLE and ans_valid outside WAIT_ANS SHALL be ignored without side effects.
REQ-028 start in the same cycle as the RESULT exit SHALL be ignored; the block reaches IDLE first.
REQ-029 A captured ans_in above 99 SHALL compare as-is and therefore always score wrong.
REQ-030 Outputs SHALL be registered, with no combinational path from any input to any output except ans_in to disp_out in WAIT_ANS.

Reset
REQ-031 rst_n low SHALL immediately force, from any state including mid-SHOW or mid-WAIT_ANS:
- state IDLE
- disp_out, sum, tick_cnt, slot and score = 0
- correct, rand_req, round_done and busy = 0
REQ-032 score SHALL be cleared only by reset, never by start.

Configuration
REQ-033 Macro ANSWER_TIMEOUT_EN, when defined:
- WAIT_ANS counts phases.
- After ANS_PHASES*PHASE_TICKS cycles with no accepted answer, go to CHECK with correct forced 0 and score unchanged.
REQ-034 Without ANSWER_TIMEOUT_EN, WAIT_ANS SHALL wait indefinitely and ANS_PHASES SHALL be unused.

Verification
REQ-035 PHASE_TICKS=4, rand_in sequence 3,7,12,30,31, answer 83 -> disp_out shows 3,7,12,30,31, then 0, then 83; correct=1; score=1; exactly one round_done pulse.
REQ-036 Same operands, answer 82 -> correct=0, score unchanged, RESULT shows 83.
REQ-037 rand_in held at 31 for all five slots, answer 55 -> correct=1, confirming the modulo-100 wrap (155 becomes 55).
REQ-038 Eight consecutive correct rounds -> score sequence 1..7, then stays 7.
REQ-039 rst_n pulsed low during slot 3 of SHOW -> all outputs 0 immediately; a following start begins a clean round with score 0.
REQ-040 With ANSWER_TIMEOUT_EN, ANS_PHASES=2, PHASE_TICKS=4 and no ans_valid -> CHECK is entered 8 cycles after WAIT_ANS entry, correct=0, and an ans_valid arriving later is ignored.
